// File: rtl/mat_pkg.sv
// Shared definitions for the matrix-multiply engine.
//   state_e       : engine FSM states
//   cnt_width()   : width of an i/j/k index counter for a given ORDER
//   acc_width()   : accumulator width that cannot overflow for ORDER unsigned
//                   DW x DW products
//   ACCW / CNTW   : those widths for the default ORDER=2, DW=8 configuration
//   STAT_*_BIT    : bit positions of done/busy in the peripheral status word
package mat_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_MAC,
    ST_WR,
    ST_DONE
  } state_e;

  // A counter still needs one bit when ORDER=1 (it only ever holds 0).
  function automatic int cnt_width(input int order);
    return (order > 1) ? $clog2(order) : 1;
  endfunction

  function automatic int acc_width(input int order, input int dw);
    return 2 * dw + $clog2(order);
  endfunction

  localparam int ORDER_DEFAULT = 2;
  localparam int DW_DEFAULT    = 8;
  localparam int ACCW          = acc_width(ORDER_DEFAULT, DW_DEFAULT);
  localparam int CNTW          = cnt_width(ORDER_DEFAULT);

  localparam int STAT_DONE_BIT = 0;
  localparam int STAT_BUSY_BIT = 1;

endpackage

// File: rtl/mat_mac_unit.sv
// Multiply-accumulate datapath for one C element.
//   clk, reset : clock and synchronous active-high reset
//   clr_i      : zero the accumulator on the next edge (wins over en_i)
//   en_i       : add a_i * b_i into the accumulator on the next edge
//   a_i, b_i   : unsigned DW-bit operands
//   acc_o      : registered accumulator value
module mat_mac_unit
  import mat_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int ACC_W = ACCW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [DW-1:0]    a_i,
  input  logic [DW-1:0]    b_i,
  output logic [ACC_W-1:0] acc_o
);

  logic [2*DW-1:0]  prod;
  logic [ACC_W-1:0] acc_q, acc_d;

  assign prod = a_i * b_i;

  always_comb begin
    if (clr_i)     acc_d = '0;
    else if (en_i) acc_d = acc_q + ACC_W'(prod);
    else           acc_d = acc_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/mat_mult_engine.sv
// Sequential square-matrix multiplier C = A x B over row-major word memories.
//   clk, reset       : clock and synchronous active-high reset
//   start            : one-cycle request, honoured only while idle
//   a_addr / a_rdata : A read port, data valid one cycle after the address
//   b_addr / b_rdata : B read port, same latency
//   c_we, c_addr,
//   c_wdata          : C write port, one strobe per result element
//   busy             : operation in progress
//   done             : sticky completion flag, cleared by reset or a new start
// Each element costs ORDER x (RD, MAC) plus one WR cycle.
module mat_mult_engine
  import mat_pkg::*;
#(
  parameter int ORDER = 2,
  parameter int DW    = 8,
  parameter int AW    = 22
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic [AW-1:0] a_addr,
  input  logic [31:0]   a_rdata,
  output logic [AW-1:0] b_addr,
  input  logic [31:0]   b_rdata,
  output logic          c_we,
  output logic [AW-1:0] c_addr,
  output logic [31:0]   c_wdata,
  output logic          busy,
  output logic          done
);

  localparam int ACC_W = acc_width(ORDER, DW);
  localparam int CNT_W = cnt_width(ORDER);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(ORDER - 1);
  localparam logic [AW-1:0]    ORDER_A = AW'(ORDER);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic             busy_q, busy_d, done_q, done_d, c_we_q, c_we_d;
  logic [AW-1:0]    a_addr_q, a_addr_d, b_addr_q, b_addr_d, c_addr_q, c_addr_d;
  logic [ACC_W-1:0] acc;
  logic             mac_clr, mac_en;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    busy_d  = busy_q;
    done_d  = done_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RD;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      ST_RD: state_d = ST_MAC;
      ST_MAC: begin
        if (k_q == LAST) begin
          state_d = ST_WR;
        end else begin
          k_d     = k_q + CNT_W'(1);
          state_d = ST_RD;
        end
      end
      ST_WR: begin
        k_d     = '0;
        state_d = ST_RD;
        if (j_q == LAST) begin
          j_d = '0;
          if (i_q == LAST) begin
            i_d     = '0;
            state_d = ST_DONE;
          end else begin
            i_d = i_q + CNT_W'(1);
          end
        end else begin
          j_d = j_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Addresses and the write strobe are computed from next-state values so
    // the registered outputs line up with the state they belong to.
    c_we_d   = (state_d == ST_WR);
    a_addr_d = AW'(i_d) * ORDER_A + AW'(k_d);
    b_addr_d = AW'(k_d) * ORDER_A + AW'(j_d);
    c_addr_d = AW'(i_d) * ORDER_A + AW'(j_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      c_we_q   <= 1'b0;
      a_addr_q <= '0;
      b_addr_q <= '0;
      c_addr_q <= '0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      c_we_q   <= c_we_d;
      a_addr_q <= a_addr_d;
      b_addr_q <= b_addr_d;
      c_addr_q <= c_addr_d;
    end
  end

  // Operands arrive in MAC (one cycle after RD presented the address); the
  // sum is final during WR and cleared on the edge leaving it.
  assign mac_en  = (state_q == ST_MAC);
  assign mac_clr = (state_q == ST_WR) || ((state_q == ST_IDLE) && start);

  mat_mac_unit #(
    .DW    (DW),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .clr_i (mac_clr),
    .en_i  (mac_en),
    .a_i   (a_rdata[DW-1:0]),
    .b_i   (b_rdata[DW-1:0]),
    .acc_o (acc)
  );

  generate
    if (ACC_W >= 32) begin : g_trunc
      assign c_wdata = acc[31:0];
    end else begin : g_zext
      assign c_wdata = {{(32 - ACC_W){1'b0}}, acc};
    end
    if (DW < 32) begin : g_hi_unused
      // Only the low DW bits of each word carry an element.
      logic unused_rdata_hi;
      assign unused_rdata_hi = ^{a_rdata[31:DW], b_rdata[31:DW]};
    end
  endgenerate

  assign a_addr = a_addr_q;
  assign b_addr = b_addr_q;
  assign c_addr = c_addr_q;
  assign c_we   = c_we_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
